wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-precision add/subtract controller that time-multiplexes one carry_lookahead_adder of WIDTH bits over WORDS operand words, least-significant word first.
- Produces a WORDS*WIDTH-bit sum or difference.
- The carry is chained between words through a carry register.
- Valid/ready handshakes sit on the input and output sides, so the block can be used as a shared wide-arithmetic unit behind a bus or pipeline stage.

Parameters:
- WIDTH, 32, width of the internal carry_lookahead_adder and of one operand word.
- WORDS, 4, number of words per operand (WORDS >= 2); full operand width is WORDS*WIDTH.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WORDS*WIDTH  first operand.
- b  input  WORDS*WIDTH  second operand.
- sub  input  1  0: a+b; 1: a-b (two's complement).
- out_valid  output  1  result, c_out and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WORDS*WIDTH  sum or difference, modulo 2^(WORDS*WIDTH).
- c_out  output  1  final carry out of the MSB word; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow of the full-width operation.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, c_out=0, overflow=0, word index=0, carry register=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On posedge with in_valid=1, capture a, b and sub into operand registers. Store b as ~b when sub=1. Set carry register=sub, index=0, go to RUN.
  - RUN: each cycle the adder sees operand word[index] of a, operand word[index] of the (possibly inverted) b, and c_in=carry register.
    - On posedge: result word[index] <= sum, carry register <= adder c_out, index <= index+1.
    - When index==WORDS-1: c_out <= adder c_out; overflow <= (a_msb == b_eff_msb) && (sum_msb != a_msb); go to DONE.
  - DONE: out_valid=1; result, c_out and overflow held stable. On posedge with out_ready=1, go to IDLE (out_valid drops next cycle; result register retains its value).
- Latency: handshake at posedge k; out_valid is high starting after posedge k+WORDS (exactly WORDS RUN cycles). Throughput is one operation per WORDS+2 cycles when out_ready is tied high.
- in_ready is combinationally (state==IDLE). in_valid outside IDLE is ignored and no operands are captured. Operands are registered at accept, so a and b may change after the handshake.
- out_ready outside DONE is ignored. out_valid never deasserts without a handshake or reset.
- Index counter width is clog2(WORDS), minimum 1. The index never wraps past WORDS-1 inside RUN.
- rst=1 at any posedge overrides everything, including mid-RUN and DONE. Any in-flight operation is discarded and no result is produced. A simultaneous in_valid in the reset cycle is not accepted.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- Carry chain, defaults (128-bit): a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, sub=0 -> result=0x00000001_00000000_00000000_00000000, c_out=0, overflow=0, out_valid rises exactly 4 cycles after the accept edge.
- Full wrap: a=all ones, b=1, sub=0 -> result=0, c_out=1, overflow=0.
- Subtract with borrow: a=5, b=7, sub=1 -> result=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, c_out=0, overflow=0. Then a=7, b=5, sub=1 -> result=2, c_out=1.
- Signed overflow: a=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, sub=0 -> result=0x80000000_00000000_00000000_00000000, overflow=1, c_out=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> result held, in_ready=0, no second capture. Raising out_ready -> back to IDLE next cycle.
  - Separately, assert rst on the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, result=0, in_ready=1.
- Random regression: 1000 random a/b/sub with random out_ready stalls -> every result equals (a ± b) mod 2^128, and c_out and overflow match a golden model.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-word add/subtract that reuses one WIDTH-bit carry-lookahead adder,
// processing the least-significant word first with a registered inter-word carry.
module carry_lookahead_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   logic [WIDTH-1:0] g, p;
   logic             cy;
   assign g = a & b;
   assign p = a ^ b;
   always_comb begin
      sum = '0;
      cy = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = p[i] ^ cy;
         cy = g[i] | (p[i] & cy);
      end
      c_out = cy;
   end
endmodule

module wide_add_sequencer #(
   parameter int WIDTH = 32,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORDS*WIDTH-1:0] a,
   input  logic [WORDS*WIDTH-1:0] b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORDS*WIDTH-1:0] result,
   output logic                   c_out,
   output logic                   overflow,
   output logic                   busy
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                 state;
   logic [WORDS*WIDTH-1:0] a_q, b_q;
   logic                   carry;
   logic [IW-1:0]          idx;
   logic [WIDTH-1:0]       a_w, b_w, s_w;
   logic                   c_w;
   assign a_w = a_q[int'(idx)*WIDTH +: WIDTH];
   assign b_w = b_q[int'(idx)*WIDTH +: WIDTH];
   assign in_ready = (state == IDLE);
   carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
      .a(a_w),
      .b(b_w),
      .c_in(carry),
      .sum(s_w),
      .c_out(c_w)
   );
   // b is stored already inverted for subtraction; the +1 enters through the initial carry
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out_valid <= 1'b0;
         busy <= 1'b0;
         result <= '0;
         c_out <= 1'b0;
         overflow <= 1'b0;
         idx <= '0;
         carry <= 1'b0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q <= a;
               b_q <= sub ? ~b : b;
               carry <= sub;
               idx <= '0;
               busy <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               result[int'(idx)*WIDTH +: WIDTH] <= s_w;
               carry <= c_w;
               if (idx == LAST) begin
                  c_out <= c_w;
                  overflow <= (a_w[WIDTH-1] == b_w[WIDTH-1]) && (s_w[WIDTH-1] != a_w[WIDTH-1]);
                  out_valid <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed and random checks of the 128-bit add/subtract sequencer.
module tb_wide_add_sequencer;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] a_i = '0;
   logic [127:0] b_i = '0;
   logic         sub_i = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] result;
   logic         c_out;
   logic         overflow;
   logic         busy;
   int           checks = 0;
   int           errors = 0;

   wide_add_sequencer dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a_i),
      .b(b_i),
      .sub(sub_i),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .c_out(c_out),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Runs one operation; lat is the number of edges from accept to out_valid (99 on timeout).
   task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic s,
                        input int stall, input bit handshake,
                        output logic [127:0] r, output logic co, output logic ov, output int lat);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      a_i = a; b_i = b; sub_i = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0; a_i = rnd128(); b_i = rnd128(); sub_i = ~s;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!out_valid) lat = 99;
      r = result; co = c_out; ov = overflow;
      for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
      if (handshake) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, c_out, overflow} !== 5'b10000 || result !== '0) begin
         errors++;
         $display("FAIL reset got rdy/ov/busy/co/ovf=%b result=%h exp 10000 result=0",
                  {in_ready, out_valid, busy, c_out, overflow}, result);
      end
   endtask

   task automatic test_carry_chain();
      logic [127:0] r; logic co, ov; int lat;
      do_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 0, 1'b1, r, co, ov, lat);
      checks++;
      if (r !== 128'h00000001_00000000_00000000_00000000) begin errors++; $display("FAIL carry_chain result got %h exp %h", r, 128'h00000001_00000000_00000000_00000000); end
      checks++;
      if ({co, ov} !== 2'b00) begin errors++; $display("FAIL carry_chain flags got co=%b ov=%b exp 0 0", co, ov); end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL carry_chain latency got %0d exp 4", lat); end
   endtask

   task automatic test_wrap();
      logic [127:0] r; logic co, ov; int lat;
      do_op({128{1'b1}}, 128'd1, 1'b0, 0, 1'b1, r, co, ov, lat);
      checks++;
      if (r !== '0 || {co, ov} !== 2'b10) begin errors++; $display("FAIL wrap got %h co=%b ov=%b exp 0 co=1 ov=0", r, co, ov); end
   endtask

   task automatic test_sub();
      logic [127:0] r; logic co, ov; int lat;
      do_op(128'd5, 128'd7, 1'b1, 1, 1'b1, r, co, ov, lat);
      checks++;
      if (r !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE || {co, ov} !== 2'b00) begin
         errors++; $display("FAIL sub_borrow got %h co=%b ov=%b exp ..FFFE co=0 ov=0", r, co, ov);
      end
      do_op(128'd7, 128'd5, 1'b1, 0, 1'b1, r, co, ov, lat);
      checks++;
      if (r !== 128'd2 || {co, ov} !== 2'b10) begin errors++; $display("FAIL sub_no_borrow got %h co=%b ov=%b exp 2 co=1 ov=0", r, co, ov); end
   endtask

   task automatic test_overflow();
      logic [127:0] r; logic co, ov; int lat;
      do_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 0, 1'b1, r, co, ov, lat);
      checks++;
      if (r !== {1'b1, 127'd0} || {co, ov} !== 2'b01) begin errors++; $display("FAIL overflow_add got %h co=%b ov=%b exp 8000.. co=0 ov=1", r, co, ov); end
      do_op({1'b1, 127'd0}, 128'd1, 1'b1, 0, 1'b1, r, co, ov, lat);
      checks++;
      if (r !== {1'b0, {127{1'b1}}} || {co, ov} !== 2'b11) begin errors++; $display("FAIL overflow_sub got %h co=%b ov=%b exp 7FFF.. co=1 ov=1", r, co, ov); end
   endtask

   task automatic test_backpressure();
      logic [127:0] r; logic co, ov; int lat;
      do_op(128'd100, 128'd23, 1'b0, 0, 1'b0, r, co, ov, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a_i = rnd128(); b_i = rnd128(); sub_i = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (result !== 128'd123 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold cycle %0d got result=%h rdy=%b ov=%b exp 7b 0 1", i, result, in_ready, out_valid);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 128'd123) begin
         errors++; $display("FAIL stall_release got rdy=%b ov=%b busy=%b result=%h exp 1 0 0 7b", in_ready, out_valid, busy, result);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_capture got busy=%b exp 0", busy); end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a_i = 128'd9; b_i = 128'd9; sub_i = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
         errors++; $display("FAIL reset_mid_run got rdy=%b ov=%b busy=%b result=%h exp 1 0 0 0", in_ready, out_valid, busy, result);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_discard got ov=%b busy=%b exp 0 0", out_valid, busy); end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_with_valid got busy=%b rdy=%b exp 0 1", busy, in_ready); end
   endtask

   task automatic test_random();
      logic [127:0] a, b, be, r; logic s, co, ov; int lat;
      logic [128:0] full;
      for (int n = 0; n < 1000; n++) begin
         a = rnd128(); b = rnd128(); s = 1'($urandom_range(0, 1));
         if (n % 50 == 0) b = ~a;
         be = s ? ~b : b;
         full = {1'b0, a} + {1'b0, be} + 129'(s);
         do_op(a, b, s, int'($urandom_range(0, 3)), 1'b1, r, co, ov, lat);
         checks++;
         if (r !== full[127:0] || co !== full[128] || lat !== 4) begin
            errors++; $display("FAIL random %0d a=%h b=%h sub=%b got %h co=%b lat=%0d exp %h co=%b lat=4", n, a, b, s, r, co, lat, full[127:0], full[128]);
         end
         checks++;
         if (ov !== ((a[127] == be[127]) && (full[127] != a[127]))) begin
            errors++; $display("FAIL random_ovf %0d got %b exp %b", n, ov, (a[127] == be[127]) && (full[127] != a[127]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_carry_chain();
      test_wrap();
      test_sub();
      test_overflow();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
